hd_frame_rx: RTL and testbench
==============================

# hd_frame_rx

Serial front-end for the Hamming(7,4) decoder. It accepts a bit-serial stream, finds 14-bit frames using a start-of-frame marker, and deserialises each frame into the two 7-bit code words the decoder consumes. Each word also gets a syndrome-clean flag, because the decoder always assumes exactly one error. Frames are presented on a registered valid/ready output with one holding slot, so the serial side keeps flowing while downstream stalls for at most one frame.

## Interface
- CW_W, 7: code word width; bit order {p1,p2,p3,x1,x2,x3,x4} = [6:0].
- DROP_W, 8: width of the dropped-frame counter.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  a serial bit is offered this cycle.
- in_sof  in  1  qualifies in_bit as the first bit of a frame; meaningful only with in_valid.
- in_bit  in  1  serial data.
- in_ready  out  1  bit is accepted when in_valid & in_ready.
- out_valid  out  1  code_word1/code_word2/out_clean hold a complete frame.
- out_ready  in  1  downstream takes the frame when out_valid & out_ready.
- code_word1  out  7  first word of the frame.
- code_word2  out  7  second word of the frame.
- out_clean  out  2  [1] word1 syndrome is zero; [0] word2 syndrome is zero.
- drop_cnt  out  DROP_W  saturating count of aborted frames.

## Operation
- Frame format: 14 bits, MSB first. Beat 0 (with in_sof) is code_word1[6]; beat 6 is code_word1[0]; beats 7..13 are code_word2[6:0].
- Parity is even:
  - s1 = p1^x1^x2^x3
  - s2 = p2^x1^x2^x4
  - s3 = p3^x1^x3^x4
  - A word is clean iff s1 = s2 = s3 = 0.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: in_ready = 1. An accepted beat with in_sof = 0 is discarded and not counted. An accepted beat with in_sof = 1 loads shift reg bit 13, sets bit_cnt = 1, and moves to SHIFT.
  - SHIFT: in_ready = 1. Each accepted beat shifts in and increments bit_cnt.
    - An accepted beat with in_sof = 1 aborts the partial frame: drop_cnt increments (saturates at all-ones), the beat becomes beat 0 of the new frame, bit_cnt = 1, and the state stays SHIFT.
    - When beat 13 is accepted and the output slot is free (out_valid = 0, or out_valid & out_ready in the same cycle), the frame and flags load into the output register next edge and the FSM goes to IDLE.
    - If the slot is not free, the frame stays in the shift register and the FSM goes to HOLD.
  - HOLD: in_ready = 0. When the output slot frees (the handshake completes), the shift register contents load into the output register next edge and the FSM goes to IDLE.
- The output register holds its value until its handshake completes. out_valid deasserts after the handshake unless a new frame loads on the same edge.
- in_sof on beat 13 of a frame counts as an abort, not as a completion.
- bit_cnt is 4 bits, range 0..13, and never wraps past 13.

## Timing
- Reset (rst_n low, asynchronous) clears everything:
  - FSM = IDLE, bit_cnt = 0, shift reg = 0, drop_cnt = 0.
  - Outputs: in_ready = 1, out_valid = 0, code_word1 = 0, code_word2 = 0, out_clean = 2'b00.
- Asserting reset mid-frame or while HOLD is pending discards the frame immediately. It is not counted in drop_cnt.
- Latency: beat 13 accepted at edge N gives out_valid = 1 after edge N (visible in cycle N+1) when the slot is free.
- Throughput: one bit per cycle. Back-to-back frames with in_sof on the very next beat are legal.
- in_ready is a registered function of the FSM state only. It does not combinationally depend on out_ready.
- Stall depth: one frame in the output register plus one complete frame in the shift register. The serial side stalls only after both are full.
- A drop_cnt update is visible on the edge after the aborting beat.

## Structure
- Shared package hd_pkg holds:
  - CW_W and the frame length constant (2*CW_W).
  - The state enum {IDLE, SHIFT, HOLD}.
  - Bit index constants P1 = 6, P2 = 5, P3 = 4, X1 = 3, X2 = 2, X3 = 1, X4 = 0, which the decoder also uses.
- One sub-module, hd_syndrome: combinational, takes a 7-bit word and returns the 3-bit syndrome. It is instantiated twice on the shift register halves. out_clean = ~|syndrome.

## Test plan
- Reset, then frame 7'h1B, 7'h00 with in_sof on beat 0 and out_ready = 1 → out_valid high one cycle after beat 13; code_word1 = 7'h1B, code_word2 = 7'h00, out_clean = 2'b11.
- Frame 7'h5B, 7'h01 → code_word1 = 7'h5B, code_word2 = 7'h01, out_clean = 2'b00, drop_cnt = 0.
- in_sof reasserted on beat 5 of a frame, followed by a full 7'h1B/7'h1B frame → drop_cnt = 1; output is 7'h1B/7'h1B with out_clean = 2'b11.
- out_ready = 0, three frames streamed back-to-back:
  - in_ready falls the cycle after beat 13 of frame 2.
  - Frame 1 is held unchanged.
  - Pulsing out_ready once presents frame 2 on the next cycle.
  - in_ready returns to 1 and frame 3 is accepted intact.
- Stray beats with in_sof = 0 in IDLE, then reset asserted mid-frame → stray beats are ignored; after reset all outputs are zero, in_ready = 1, drop_cnt = 0.
- 256 aborted frames with DROP_W = 8 → drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/hd_frame_rx_pkg.sv
// Shared definitions for the Hamming(7,4) serial front-end and decoder.
// Holds the word geometry, the receive FSM encoding and the syndrome helper.
package hd_pkg;

  localparam int CW_W      = 7;
  localparam int FRAME_LEN = 2 * CW_W;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  // Bit positions inside a code word, shared with the decoder.
  localparam int P1 = 6;
  localparam int P2 = 5;
  localparam int P3 = 4;
  localparam int X1 = 3;
  localparam int X2 = 2;
  localparam int X3 = 1;
  localparam int X4 = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  // Even-parity syndrome {s1,s2,s3}; all-zero means the word is clean.
  function automatic logic [2:0] calc_syndrome(input logic [CW_W-1:0] word);
    logic s1;
    logic s2;
    logic s3;
    s1 = word[P1] ^ word[X1] ^ word[X2] ^ word[X3];
    s2 = word[P2] ^ word[X1] ^ word[X2] ^ word[X4];
    s3 = word[P3] ^ word[X1] ^ word[X3] ^ word[X4];
    return {s1, s2, s3};
  endfunction

endpackage

// File: rtl/hd_frame_rx_if.sv
// Serial input stream and framed output handshake of the receive front-end.
interface hd_frame_rx_if;
  import hd_pkg::*;

  logic            in_valid;
  logic            in_sof;
  logic            in_bit;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [CW_W-1:0] code_word1;
  logic [CW_W-1:0] code_word2;
  logic [1:0]      out_clean;

  modport slave (
    input  in_valid, in_sof, in_bit, out_ready,
    output in_ready, out_valid, code_word1, code_word2, out_clean
  );

  modport master (
    output in_valid, in_sof, in_bit, out_ready,
    input  in_ready, out_valid, code_word1, code_word2, out_clean
  );

endinterface

// File: rtl/hd_syndrome.sv
// Combinational syndrome of one 7-bit Hamming code word.
module hd_syndrome
  import hd_pkg::*;
(
  input  logic [CW_W-1:0] word,
  output logic [2:0]      syndrome
);

  assign syndrome = calc_syndrome(word);

endmodule

// File: rtl/hd_frame_rx.sv
// Bit-serial frame receiver: finds SOF-marked 14-bit frames, splits them into two
// code words with clean flags, and buffers one frame behind a registered output.
module hd_frame_rx
  import hd_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hd_frame_rx_if.slave      rx,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  rx_state_e              state_r;
  rx_state_e              state_n_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [CNT_W-1:0]       bit_cnt_n_s;
  logic [FRAME_LEN-1:0]   shift_r;
  logic [FRAME_LEN-1:0]   shift_n_s;
  logic [FRAME_LEN-1:0]   load_frame_s;
  logic [CNT_W-1:0]       bit_idx_s;
  logic                   in_ready_r;
  logic                   accept_s;
  logic                   slot_free_s;
  logic                   load_out_s;
  logic                   drop_inc_s;
  logic [DROP_W-1:0]      drop_cnt_r;
  logic                   out_valid_r;
  logic [CW_W-1:0]        code_word1_r;
  logic [CW_W-1:0]        code_word2_r;
  logic [1:0]             out_clean_r;
  logic [2:0]             syn1_s;
  logic [2:0]             syn2_s;

  assign accept_s    = rx.in_valid & in_ready_r;
  assign slot_free_s = ~out_valid_r | rx.out_ready;
  assign bit_idx_s   = LAST_BEAT - bit_cnt_r;

  // Next-state, shift-register update and load/abort strobes.
  always_comb begin
    state_n_s   = state_r;
    bit_cnt_n_s = bit_cnt_r;
    shift_n_s   = shift_r;
    load_out_s  = 1'b0;
    drop_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && rx.in_sof) begin
          shift_n_s   = {rx.in_bit, {(FRAME_LEN-1){1'b0}}};
          bit_cnt_n_s = CNT_W'(1);
          state_n_s   = SHIFT;
        end else begin
          state_n_s = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s && rx.in_sof) begin
          // A new SOF restarts framing even on what would be the last beat.
          drop_inc_s  = 1'b1;
          shift_n_s   = {rx.in_bit, {(FRAME_LEN-1){1'b0}}};
          bit_cnt_n_s = CNT_W'(1);
        end else if (accept_s) begin
          shift_n_s[bit_idx_s] = rx.in_bit;
          if (bit_cnt_r == LAST_BEAT) begin
            if (slot_free_s) begin
              load_out_s  = 1'b1;
              bit_cnt_n_s = {CNT_W{1'b0}};
              state_n_s   = IDLE;
            end else begin
              state_n_s = HOLD;
            end
          end else begin
            bit_cnt_n_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          state_n_s = SHIFT;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          load_out_s  = 1'b1;
          bit_cnt_n_s = {CNT_W{1'b0}};
          state_n_s   = IDLE;
        end else begin
          state_n_s = HOLD;
        end
      end
      default: begin
        state_n_s   = IDLE;
        bit_cnt_n_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // The completing beat is not yet in shift_r, so SHIFT loads from the next value.
  always_comb begin
    load_frame_s = shift_n_s;
    if (state_r == HOLD) begin
      load_frame_s = shift_r;
    end else begin
      load_frame_s = shift_n_s;
    end
  end

  hd_syndrome u_syn1 (
    .word     (load_frame_s[FRAME_LEN-1:CW_W]),
    .syndrome (syn1_s)
  );

  hd_syndrome u_syn2 (
    .word     (load_frame_s[CW_W-1:0]),
    .syndrome (syn2_s)
  );

  // FSM, deserialiser and drop counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= {CNT_W{1'b0}};
      shift_r    <= {FRAME_LEN{1'b0}};
      in_ready_r <= 1'b1;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      state_r    <= state_n_s;
      bit_cnt_r  <= bit_cnt_n_s;
      shift_r    <= shift_n_s;
      in_ready_r <= (state_n_s != HOLD);
      if (drop_inc_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_W'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Output slot: loads a finished frame, otherwise clears valid on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      code_word1_r <= {CW_W{1'b0}};
      code_word2_r <= {CW_W{1'b0}};
      out_clean_r  <= 2'b00;
    end else if (load_out_s) begin
      out_valid_r  <= 1'b1;
      code_word1_r <= load_frame_s[FRAME_LEN-1:CW_W];
      code_word2_r <= load_frame_s[CW_W-1:0];
      out_clean_r  <= {~|syn1_s, ~|syn2_s};
    end else if (out_valid_r && rx.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign rx.in_ready   = in_ready_r;
  assign rx.out_valid  = out_valid_r;
  assign rx.code_word1 = code_word1_r;
  assign rx.code_word2 = code_word2_r;
  assign rx.out_clean  = out_clean_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_hd_frame_rx.sv
// Scoreboard bench for hd_frame_rx: a bit-queue reference model predicts frames,
// a negedge monitor compares every output handshake against the expected queue.
module tb_hd_frame_rx;
  import hd_pkg::*;

  typedef struct {
    logic [6:0] w1;
    logic [6:0] w2;
    logic [1:0] cl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drop_cnt;
  hd_frame_rx_if bus();

  exp_t exp_q[$];
  bit   cur[$];
  int   abort_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tog_run;

  hd_frame_rx #(.DROP_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clean means the word appears in the codebook built from all 16 data nibbles.
  function automatic bit is_cw(input logic [6:0] w);
    logic [6:0] c;
    logic [3:0] d;
    for (int k = 0; k < 16; k++) begin
      d = 4'(k);
      c = {d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d};
      if (c == w) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_drop();
    return (abort_cnt > 255) ? 8'hFF : 8'(abort_cnt);
  endfunction

  task automatic model_accept(input bit sof, input bit b);
    exp_t e;
    logic [13:0] f;
    if (sof) begin
      if (cur.size() > 0) abort_cnt++;
      cur.delete();
      cur.push_back(b);
    end else if (cur.size() > 0) begin
      cur.push_back(b);
      if (cur.size() == 14) begin
        for (int k = 0; k < 14; k++) f[13-k] = cur[k];
        e.w1 = f[13:7];
        e.w2 = f[6:0];
        e.cl = {is_cw(e.w1), is_cw(e.w2)};
        exp_q.push_back(e);
        cur.delete();
      end
    end
  endtask

  task automatic send_beat(input bit sof, input bit b);
    bit rdy;
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_bit   = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (done) begin
      model_accept(sof, b);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got no in_ready expected acceptance");
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] w1, input logic [6:0] w2);
    logic [13:0] f;
    f = {w1, w2};
    for (int i = 0; i < 14; i++) send_beat(i == 0, f[13-i]);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_beat(i == 0, 1'($urandom));
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: a handshake seen at negedge completes on the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got %0h/%0h expected none", bus.code_word1, bus.code_word2);
      end else begin
        e = exp_q.pop_front();
        chk("code_word1", bus.code_word1, e.w1);
        chk("code_word2", bus.code_word2, e.w2);
        chk("out_clean", bus.out_clean, e.cl);
      end
    end
  end

  initial begin
    logic [6:0] f1a, f1b, f2a, f2b, f3a, f3b;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cw1", bus.code_word1, 0);
    chk("rst_clean", bus.out_clean, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean frame and first-frame latency
    bus.out_ready = 1'b1;
    send_frame(7'h1B, 7'h00);
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1);
    chk("clean_pair", bus.out_clean, 2'b11);
    @(posedge clk);
    #1;
    send_frame(7'h5B, 7'h01);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_zero", drop_cnt, 0);

    // Abort on beat 5, then a full frame
    send_partial(5);
    send_frame(7'h1B, 7'h1B);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_one", drop_cnt, exp_drop());
    drain();

    // Stall: output slot and shift register both fill
    f1a = 7'($urandom); f1b = 7'($urandom);
    f2a = 7'($urandom); f2b = 7'($urandom);
    f3a = 7'($urandom); f3b = 7'($urandom);
    bus.out_ready = 1'b0;
    send_frame(f1a, f1b);
    send_frame(f2a, f2b);
    @(negedge clk);
    chk("in_ready_fall", bus.in_ready, 0);
    fork
      send_frame(f3a, f3b);
      begin
        repeat (3) @(negedge clk);
        chk("hold_cw1", bus.code_word1, f1a);
        chk("hold_cw2", bus.code_word2, f1b);
        chk("hold_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("present_valid", bus.out_valid, 1);
        chk("present_cw1", bus.code_word1, f2a);
        chk("present_cw2", bus.code_word2, f2b);
        chk("in_ready_back", bus.in_ready, 1);
      end
    join
    drain();

    // Randomized traffic with aborts, stray beats and random backpressure
    tog_run = 1'b1;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          if ($urandom_range(0, 5) == 0) send_beat(1'b0, 1'($urandom));
          if ($urandom_range(0, 6) == 0) send_partial($urandom_range(1, 13));
          send_frame(7'($urandom), 7'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        tog_run = 1'b0;
      end
      while (tog_run) begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'($urandom);
      end
    join
    drain();
    chk("rand_drop", drop_cnt, exp_drop());

    // Stray beats ignored, then reset mid-frame
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk("stray_drop", drop_cnt, exp_drop());
    chk("stray_valid", bus.out_valid, 0);
    send_partial(6);
    rst_n = 1'b0;
    cur.delete();
    abort_cnt = 0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_cw1", bus.code_word1, 0);
    chk("mid_rst_cw2", bus.code_word2, 0);
    chk("mid_rst_clean", bus.out_clean, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_drop", drop_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 256 aborts saturate the counter
    for (int i = 0; i < 257; i++) send_beat(1'b1, 1'($urandom));
    @(negedge clk);
    chk("drop_sat", drop_cnt, exp_drop());
    chk("drop_sat_ff", drop_cnt, 8'hFF);
    send_frame(7'h1B, 7'h00);
    drain();
    chk("final_drop", drop_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
